cost_unit: RTL and testbench

Hardware training-cost stage placed directly downstream of the `array_prod` output perceptron. On each new perceptron result it applies a shift-only piecewise-linear sigmoid and compares the result with the 1-bit target label. It then produces the squared-error cost word and the one-cycle `newCostFunc` strobe that drive the `network` block's `costFunc`/`newCostFunc` training inputs. It also reports the rounded class decision and keeps a saturating misclassification counter.

---
 rtl/cost_unit.sv | 131 +++++++++++++
 tb/tb_cost_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cost_unit.sv
// Training-cost stage: piecewise-linear sigmoid of the perceptron output, squared error
// against the target label, class decision and a saturating misclassification counter.
module cost_unit #(
    parameter int          QN        = 6,
    parameter int          QM        = 11,
    parameter int          BITWIDTH  = QN + QM + 1,
    parameter logic [15:0] WRONG_MAX = 16'hFFFF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [BITWIDTH-1:0] dataIn,
    input  logic                       dataValid,
    input  logic                       modelOutput,
    input  logic                       clearStats,
    output logic        [BITWIDTH-1:0] costFunc,
    output logic                       newCostFunc,
    output logic                       prediction,
    output logic                       busy,
    output logic                       overrun,
    output logic        [15:0]         wrongCount
);

    typedef enum logic [2:0] {IDLE, ABS, SIG, SQR, DONE} state_t;

    localparam logic [QM:0] ONE  = {1'b1, {QM{1'b0}}};
    localparam logic [QM:0] HALF = {2'b01, {(QM-1){1'b0}}};

    state_t                     state;
    logic                       dValidQ;
    logic                       start;
    logic signed [BITWIDTH-1:0] xP0;
    logic                       tgtP0;
    logic        [BITWIDTH-2:0] absP1;
    logic                       negP1;
    logic        [QM:0]         sP2;
    logic        [QM:0]         costP3;
    logic                       predP3;

    // Magnitude with the single unrepresentable value (-2^17) clamped to 2^17-1.
    function automatic logic [BITWIDTH-2:0] absSat(input logic signed [BITWIDTH-1:0] x);
        if (x == {1'b1, {(BITWIDTH-1){1'b0}}})
            return {(BITWIDTH-1){1'b1}};
        else if (x[BITWIDTH-1])
            return (BITWIDTH-1)'(-x);
        else
            return (BITWIDTH-1)'(x);
    endfunction

    // Positive-half sigmoid, shift-and-add segments; every branch stays within 0..ONE.
    function automatic logic [QM:0] sigPos(input logic [BITWIDTH-2:0] a);
        if (a >= (BITWIDTH-1)'(10240))
            return ONE;
        else if (a >= (BITWIDTH-1)'(4864))
            return (QM+1)'(a >> 5) + (QM+1)'(1728);
        else if (a >= (BITWIDTH-1)'(2048))
            return (QM+1)'(a >> 3) + (QM+1)'(1280);
        else
            return (QM+1)'(a >> 2) + (QM+1)'(1024);
    endfunction

    function automatic logic [QM:0] sqCost(input logic [QM:0] e);
        logic [2*QM+1:0] p;
        p = {{(QM+1){1'b0}}, e} * {{(QM+1){1'b0}}, e};
        return (QM+1)'(p >> QM);
    endfunction

    assign start = dataValid & ~dValidQ;
    assign busy  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            dValidQ     <= 1'b0;
            costFunc    <= '0;
            newCostFunc <= 1'b0;
            prediction  <= 1'b0;
            overrun     <= 1'b0;
            wrongCount  <= '0;
        end else begin
            dValidQ     <= dataValid;
            newCostFunc <= 1'b0;
            case (state)
                IDLE: if (start) state <= ABS;
                ABS:  state <= SIG;
                SIG:  state <= SQR;
                SQR:  state <= DONE;
                DONE: begin
                    costFunc    <= {{(BITWIDTH-QM-1){1'b0}}, costP3};
                    prediction  <= predP3;
                    newCostFunc <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A clear outranks both a same-edge overrun and a same-edge miss.
            if (clearStats) begin
                wrongCount <= '0;
                overrun    <= 1'b0;
            end else begin
                if (start && state != IDLE)
                    overrun <= 1'b1;
                if (state == DONE && predP3 != tgtP0 && wrongCount != WRONG_MAX)
                    wrongCount <= wrongCount + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        case (state)
            // p0: capture sample and label
            IDLE: if (start) begin
                xP0   <= dataIn;
                tgtP0 <= modelOutput;
            end
            // p1: sign and saturated magnitude
            ABS: begin
                absP1 <= absSat(xP0);
                negP1 <= xP0[BITWIDTH-1];
            end
            // p2: sigmoid, mirrored about 0.5 for negative inputs
            SIG: sP2 <= negP1 ? ONE - sigPos(absP1) : sigPos(absP1);
            // p3: squared error and class decision
            SQR: begin
                costP3 <= sqCost(tgtP0 ? ONE - sP2 : sP2);
                predP3 <= (sP2 >= HALF);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cost_unit.sv
// Randomised scoreboard bench for cost_unit: a behavioural model predicts each result,
// a negedge monitor pops and compares on every newCostFunc strobe.
module tb_cost_unit;

    localparam int          QN   = 6;
    localparam int          QM   = 11;
    localparam int          BW   = QN + QM + 1;
    localparam logic [15:0] WMAX = 16'd40;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic signed [BW-1:0] dataIn = '0;
    logic                 dataValid = 1'b0;
    logic                 modelOutput = 1'b0;
    logic                 clearStats = 1'b0;
    logic        [BW-1:0] costFunc;
    logic                 newCostFunc;
    logic                 prediction;
    logic                 busy;
    logic                 overrun;
    logic        [15:0]   wrongCount;

    cost_unit #(.QN(QN), .QM(QM), .BITWIDTH(BW), .WRONG_MAX(WMAX)) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
        .modelOutput(modelOutput), .clearStats(clearStats), .costFunc(costFunc),
        .newCostFunc(newCostFunc), .prediction(prediction), .busy(busy),
        .overrun(overrun), .wrongCount(wrongCount)
    );

    always #5 clock = ~clock;

    typedef struct { int cost; int pred; int wc; } exp_t;
    exp_t sbq[$];
    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    int   lastT = -100;
    int   modelWrong = 0;
    int   modelOvr = 0;
    logic prevNc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int sigRef(input int x);
        int a, sp;
        a = (x < 0) ? -x : x;
        if (a > 131071) a = 131071;
        if (a >= 10240)     sp = 2048;
        else if (a >= 4864) sp = a / 32 + 1728;
        else if (a >= 2048) sp = a / 8 + 1280;
        else                sp = a / 4 + 1024;
        return (x < 0) ? 2048 - sp : sp;
    endfunction

    function automatic int costRef(input int s, input int t);
        int e;
        e = t ? 2048 - s : s;
        return (e * e) / 2048;
    endfunction

    // Called just after the edge at which the DUT sees a start condition.
    task automatic modelStart(input int x, input int t);
        int s, p;
        if (cyc - lastT >= 5) begin
            lastT = cyc;
            s = sigRef(x);
            p = (s >= 1024) ? 1 : 0;
            if (p != t && modelWrong < int'(WMAX)) modelWrong++;
            sbq.push_back('{cost: costRef(s, t), pred: p, wc: modelWrong});
        end else begin
            modelOvr = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input int x, input int t);
        dataIn      = BW'(x);
        modelOutput = t[0];
        dataValid   = 1'b1;
        @(posedge clock);
        #1;
        dataValid = 1'b0;
        modelStart(x, t);
    endtask

    task automatic watch();
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk($sformatf("busy@T+%0d", k), busy, (k <= 3) ? 1 : 0);
            chk($sformatf("strobe@T+%0d", k), newCostFunc, (k == 4) ? 1 : 0);
        end
    endtask

    task automatic modelClear();
        sbq.delete();
        modelWrong = 0;
        modelOvr   = 0;
        lastT      = -100;
    endtask

    task automatic doReset();
        reset      = 1'b0;
        dataValid  = 1'b0;
        clearStats = 1'b0;
        idle(2);
        reset = 1'b1;
        modelClear();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".costFunc"}, costFunc, 0);
        chk({tag, ".newCostFunc"}, newCostFunc, 0);
        chk({tag, ".prediction"}, prediction, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".overrun"}, overrun, 0);
        chk({tag, ".wrongCount"}, wrongCount, 0);
    endtask

    always @(negedge clock) begin
        if (newCostFunc) begin
            chk("strobeWidth", prevNc, 0);
            if (sbq.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpectedStrobe: costFunc=%0d with no result pending", costFunc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("costFunc", costFunc, e.cost);
                chk("prediction", prediction, e.pred);
                chk("wrongCount", wrongCount, e.wc);
            end
        end
        prevNc <= newCostFunc;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
        $fatal(1, "timeout");
    end

    int dx[6] = '{0, 3072, -3072, 12288, -131072, 6144};
    int dt[6] = '{1, 0, 0, 1, 1, 0};
    int bnd[12] = '{10240, 10239, 4864, 4863, 2048, 2047, -2048, -2049,
                    -131072, 131071, -10240, -4864};

    initial begin
        doReset();
        checkAllZero("reset");

        foreach (dx[i]) begin
            issue(dx[i], dt[i]);
            watch();
        end

        for (int i = 0; i < 300; i++) begin
            int x, g;
            logic [BW-1:0] r;
            r = BW'($urandom);
            x = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 11)] : int'($signed(r));
            g = $urandom_range(1, 5);
            idle(g);
            issue(x, int'($urandom_range(0, 1)));
        end
        idle(6);
        chk("randOverrun", overrun, modelOvr);
        chk("randWrongCount", wrongCount, modelWrong);
        clearStats = 1'b1;
        idle(1);
        clearStats = 1'b0;
        modelWrong = 0;
        modelOvr   = 0;
        chk("clearOverrun", overrun, 0);
        chk("clearWrongCount", wrongCount, 0);

        // Second start at T+2 is ignored but flagged.
        issue(3072, 1);
        idle(1);
        issue(-3072, 0);
        idle(6);
        chk("overrunT2", overrun, modelOvr);
        clearStats = 1'b1;
        idle(1);
        clearStats = 1'b0;
        modelOvr = 0;
        modelWrong = 0;

        // Start at T+5 accepted, strobe at T+9.
        issue(2048, 1);
        idle(4);
        issue(-2048, 0);
        watch();
        chk("noOverrunT5", overrun, modelOvr);

        // Start at T+4 is an overrun.
        issue(4864, 0);
        idle(3);
        issue(100, 1);
        idle(6);
        chk("overrunT4", overrun, modelOvr);
        clearStats = 1'b1;
        idle(1);
        clearStats = 1'b0;
        modelOvr = 0;
        modelWrong = 0;

        // Level held high for 20 cycles yields a single evaluation.
        dataIn      = BW'(6144);
        modelOutput = 1'b1;
        dataValid   = 1'b1;
        @(posedge clock);
        #1;
        modelStart(6144, 1);
        idle(19);
        dataValid = 1'b0;
        idle(8);
        chk("heldOverrun", overrun, modelOvr);

        // Reset at T+2 aborts the evaluation.
        issue(2048, 0);
        idle(1);
        reset = 1'b0;
        idle(1);
        checkAllZero("midReset");
        reset = 1'b1;
        modelClear();
        idle(10);
        chk("midResetBusy", busy, 0);
        chk("midResetCount", wrongCount, 0);

        // Counter saturation.
        for (int i = 0; i < int'(WMAX) + 4; i++) begin
            issue(12288, 0);
            idle(4);
        end
        idle(2);
        chk("satCount", wrongCount, modelWrong);

        issue(12288, 0);
        idle(1);
        issue(0, 0);
        idle(4);
        chk("overrunBeforeClear", overrun, modelOvr);

        // Clear coincident with a counting DONE.
        issue(12288, 0);
        idle(3);
        clearStats   = 1'b1;
        sbq[$].wc    = 0;
        modelWrong   = 0;
        modelOvr     = 0;
        idle(1);
        clearStats = 1'b0;
        chk("clearWinsCount", wrongCount, 0);
        chk("clearWinsOverrun", overrun, 0);

        idle(10);
        chk("pendingResults", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
